// File: rtl/cpu_row_streamer_if.sv
// Host-to-chip row streamer bus.
// Host drives row/control, streamer returns words and row metadata.
interface cpu_row_streamer_if #(
    parameter int ROW_W  = 480,
    parameter int WORD_W = 16
);
    logic [ROW_W-1:0]  row;
    logic [WORD_W-1:0] cnnData;
    logic              cnn_image;
    logic              load_process;
    logic              send;
    logic              stop;
    logic [WORD_W-1:0] data;
    logic              startDecompression;
    logic [WORD_W-1:0] rowSize;
    logic [WORD_W-1:0] extraBits;
    logic [WORD_W-1:0] initialRowSize;
    logic [WORD_W-1:0] splitSize;

    modport master (
        output row, cnnData, cnn_image, load_process, send, stop,
        input  data, startDecompression, rowSize, extraBits,
        input  initialRowSize, splitSize
    );

    modport slave (
        input  row, cnnData, cnn_image, load_process, send, stop,
        output data, startDecompression, rowSize, extraBits,
        output initialRowSize, splitSize
    );
endinterface

// File: rtl/cpu_row_streamer.sv
// Host-side front end of the DCNN accelerator.
// Captures compressed rows and streams them as words, or forwards CNN data.
module cpu_row_streamer #(
    parameter int ROW_W  = 480,
    parameter int WORD_W = 16
) (
    input logic               clk,
    input logic               rst,
    cpu_row_streamer_if.slave bus
);
    localparam int PAY_W = ROW_W - WORD_W;
    localparam int SH    = $clog2(WORD_W);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        WAIT,
        CNN
    } state_t;

    state_t            state;
    logic              send_q;
    logic              pending;
    logic              req;
    logic [PAY_W-1:0]  pay_q;
    logic [WORD_W-1:0] cnt_q;
    logic [WORD_W-1:0] data_q;
    logic              sd_q;
    logic [WORD_W-1:0] rs_q;
    logic [WORD_W-1:0] eb_q;
    logic [WORD_W-1:0] irs_q;
    logic [WORD_W-1:0] hdr;
    logic [WORD_W-1:0] irs_c;
    logic [WORD_W-1:0] rs_c;
    logic [WORD_W-1:0] eb_c;

    assign req = bus.send & ~send_q;

    assign bus.data               = data_q;
    assign bus.startDecompression = sd_q;
    assign bus.rowSize            = rs_q;
    assign bus.extraBits          = eb_q;
    assign bus.initialRowSize     = irs_q;
    assign bus.splitSize          = WORD_W'(WORD_W);

    // Row metadata from the header: clamp, word count, padding bits.
    always_comb begin
        hdr   = bus.row[ROW_W-1 -: WORD_W];
        irs_c = (hdr > WORD_W'(PAY_W)) ? WORD_W'(PAY_W) : hdr;
        rs_c  = (irs_c + WORD_W'(WORD_W - 1)) >> SH;
        eb_c  = (rs_c << SH) - irs_c;
    end

    // Mode control, row capture and word streaming.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            send_q  <= 1'b0;
            pending <= 1'b0;
            pay_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            sd_q    <= 1'b0;
            rs_q    <= '0;
            eb_q    <= '0;
            irs_q   <= '0;
        end else begin
            send_q <= bus.send;
            sd_q   <= 1'b0;
            if (!bus.load_process) begin
                state   <= IDLE;
                data_q  <= '0;
                pending <= 1'b0;
            end else if (bus.cnn_image) begin
                state   <= CNN;
                data_q  <= bus.cnnData;
                pending <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: state <= LOAD;
                    LOAD: begin
                        if (req) pending <= 1'b1;
                        if (!bus.stop) begin
                            pay_q <= bus.row[PAY_W-1:0];
                            irs_q <= irs_c;
                            rs_q  <= rs_c;
                            eb_q  <= eb_c;
                            cnt_q <= '0;
                            sd_q  <= 1'b1;
                            state <= (rs_c == '0) ? WAIT : STREAM;
                        end
                    end
                    STREAM: begin
                        if (req) pending <= 1'b1;
                        if (!bus.stop) begin
                            data_q <= pay_q[PAY_W-1 -: WORD_W];
                            pay_q  <= pay_q << WORD_W;
                            cnt_q  <= cnt_q + WORD_W'(1);
                            if (cnt_q == rs_q - WORD_W'(1)) begin
                                if (req || pending) begin
                                    state   <= LOAD;
                                    pending <= 1'b0;
                                end else begin
                                    state <= WAIT;
                                end
                            end
                        end
                    end
                    WAIT: begin
                        if (req || pending) begin
                            state   <= LOAD;
                            pending <= 1'b0;
                        end
                    end
                    CNN:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cpu_row_streamer.sv
// Self-checking bench for cpu_row_streamer.
// Directed scenarios then random traffic against a queue-based model.
module tb_cpu_row_streamer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cpu_row_streamer_if bus ();

    cpu_row_streamer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam int MD_IDLE   = 0;
    localparam int MD_LOAD   = 1;
    localparam int MD_STREAM = 2;
    localparam int MD_WAIT   = 3;
    localparam int MD_CNN    = 4;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_mode;
    logic        m_sq;
    logic        m_pend;
    logic [15:0] m_data;
    logic        m_sd;
    logic [15:0] m_rs;
    logic [15:0] m_eb;
    logic [15:0] m_irs;
    logic [15:0] m_words[$];

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // Behavioural model: one call per rising edge, inputs as sampled.
    task automatic model();
        logic req;
        int   bits;
        int   nw;
        req  = bus.send & ~m_sq;
        m_sq = bus.send;
        if (rst) begin
            m_mode = MD_IDLE;
            m_sq   = 1'b0;
            m_pend = 1'b0;
            m_data = 16'h0;
            m_sd   = 1'b0;
            m_rs   = 16'h0;
            m_eb   = 16'h0;
            m_irs  = 16'h0;
            m_words.delete();
            return;
        end
        m_sd = 1'b0;
        if (!bus.load_process) begin
            m_mode = MD_IDLE;
            m_data = 16'h0;
            m_pend = 1'b0;
            m_words.delete();
        end else if (bus.cnn_image) begin
            m_mode = MD_CNN;
            m_data = bus.cnnData;
            m_pend = 1'b0;
            m_words.delete();
        end else begin
            case (m_mode)
                MD_IDLE: m_mode = MD_LOAD;
                MD_CNN:  m_mode = MD_IDLE;
                MD_LOAD: begin
                    if (req) m_pend = 1'b1;
                    if (!bus.stop) begin
                        bits = int'(bus.row[479:464]);
                        if (bits > 464) bits = 464;
                        nw    = (bits + 15) / 16;
                        m_irs = 16'(bits);
                        m_rs  = 16'(nw);
                        m_eb  = 16'(nw * 16 - bits);
                        m_words.delete();
                        for (int i = 0; i < nw; i++)
                            m_words.push_back(bus.row[463-16*i -: 16]);
                        m_sd   = 1'b1;
                        m_mode = (nw == 0) ? MD_WAIT : MD_STREAM;
                    end
                end
                MD_STREAM: begin
                    if (req) m_pend = 1'b1;
                    if (!bus.stop) begin
                        m_data = m_words.pop_front();
                        if (m_words.size() == 0) begin
                            m_mode = m_pend ? MD_LOAD : MD_WAIT;
                            m_pend = 1'b0;
                        end
                    end
                end
                MD_WAIT: begin
                    if (req || m_pend) begin
                        m_mode = MD_LOAD;
                        m_pend = 1'b0;
                    end
                end
                default: m_mode = MD_IDLE;
            endcase
        end
    endtask

    task automatic compare();
        chk("data", bus.data, m_data);
        chk("startDecompression", {15'h0, bus.startDecompression},
            {15'h0, m_sd});
        chk("rowSize", bus.rowSize, m_rs);
        chk("extraBits", bus.extraBits, m_eb);
        chk("initialRowSize", bus.initialRowSize, m_irs);
        chk("splitSize", bus.splitSize, 16'd16);
    endtask

    task automatic tick();
        @(posedge clk);
        model();
        #1;
        compare();
    endtask

    function automatic logic [479:0] rand_row(input logic [15:0] hdr);
        logic [479:0] r;
        for (int i = 0; i < 15; i++) r[i*32 +: 32] = $urandom();
        r[479:464] = hdr;
        return r;
    endfunction

    function automatic logic [15:0] rand_hdr();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h0011;
            2:       return 16'h0FFF;
            3:       return 16'h01D0;
            4:       return 16'(464 + $urandom_range(1, 40));
            default: return 16'($urandom_range(1, 96));
        endcase
    endfunction

    initial begin
        rst              = 1'b1;
        bus.load_process = 1'b1;
        bus.cnn_image    = 1'b0;
        bus.send         = 1'b0;
        bus.stop         = 1'b0;
        bus.cnnData      = 16'h0;
        bus.row = {16'h0020, 16'hA1A1, 16'hB2B2, 432'h0};
        m_sq = 1'b0;
        tick();
        tick();
        chk("rst_data", bus.data, 16'h0);
        chk("rst_split", bus.splitSize, 16'd16);
        chk("rst_rowSize", bus.rowSize, 16'h0);

        // first row auto-loads after reset
        rst = 1'b0;
        tick();
        tick();
        chk("r1_sd", {15'h0, bus.startDecompression}, 16'h1);
        chk("r1_rowSize", bus.rowSize, 16'd2);
        chk("r1_extraBits", bus.extraBits, 16'd0);
        chk("r1_irs", bus.initialRowSize, 16'd32);
        tick();
        chk("r1_w0", bus.data, 16'hA1A1);
        chk("r1_sd_low", {15'h0, bus.startDecompression}, 16'h0);
        tick();
        chk("r1_w1", bus.data, 16'hB2B2);
        tick();
        tick();
        chk("r1_hold", bus.data, 16'hB2B2);

        // 17-bit row
        bus.row  = rand_row(16'h0011);
        bus.send = 1'b1;
        tick();
        bus.send = 1'b0;
        tick();
        chk("r2_rowSize", bus.rowSize, 16'd2);
        chk("r2_extraBits", bus.extraBits, 16'd15);
        chk("r2_irs", bus.initialRowSize, 16'd17);
        repeat (3) tick();

        // clamped header, stop stalls, send during streaming
        bus.row  = rand_row(16'h0FFF);
        bus.send = 1'b1;
        tick();
        bus.send = 1'b0;
        tick();
        chk("r3_irs", bus.initialRowSize, 16'd464);
        chk("r3_rowSize", bus.rowSize, 16'd29);
        chk("r3_extraBits", bus.extraBits, 16'd0);
        repeat (3) tick();
        bus.stop = 1'b1;
        repeat (3) tick();
        bus.stop = 1'b0;
        tick();
        bus.send = 1'b1;
        tick();
        bus.send = 1'b0;
        bus.row  = rand_row(16'h0030);
        repeat (40) tick();

        // CNN forwarding ignores stop
        bus.cnn_image = 1'b1;
        bus.stop      = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.cnnData = 16'(i);
            tick();
            chk("cnn_data", bus.data, 16'(i));
        end
        bus.stop      = 1'b0;
        bus.cnn_image = 1'b0;
        repeat (4) tick();

        // reset mid-stream
        rst = 1'b1;
        tick();
        chk("mid_rst_data", bus.data, 16'h0);
        chk("mid_rst_irs", bus.initialRowSize, 16'h0);
        chk("mid_rst_split", bus.splitSize, 16'd16);
        rst = 1'b0;

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            rst              = ($urandom_range(0, 599) == 0);
            bus.load_process = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 79) == 0) bus.cnn_image = ~bus.cnn_image;
            bus.send    = ($urandom_range(0, 9) == 0);
            bus.stop    = ($urandom_range(0, 3) == 0);
            bus.cnnData = 16'($urandom());
            if ($urandom_range(0, 5) == 0) bus.row = rand_row(rand_hdr());
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end
endmodule
